// File: rtl/battleship_pkg.sv
// rtl/battleship_pkg.sv - shared Battleship game state codes and defaults
package battleship_pkg;

   localparam int STATE_W            = 3;
   localparam int SHIP_CELLS_DEFAULT = 17;

   // Codes 3 and 4 are decoded downstream as fire permission for P1 / P2.
   typedef enum logic [STATE_W-1:0] {
      IDLE     = 3'd0,
      P1_PLACE = 3'd1,
      P2_PLACE = 3'd2,
      P1_TURN  = 3'd3,
      P2_TURN  = 3'd4,
      P1_WIN   = 3'd5,
      P2_WIN   = 3'd6,
      UNUSED   = 3'd7
   } game_state_t;

endpackage

// File: rtl/turn_timer.sv
// rtl/turn_timer.sv - per-turn inactivity counter with terminal-count flag
module turn_timer #(
   parameter int TIMER_W      = 27,
   parameter int TURN_TIMEOUT = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   // A timeout of 0 disables the terminal flag entirely.
   localparam logic [TIMER_W-1:0] TC_VALUE =
      (TURN_TIMEOUT > 0) ? TIMER_W'(TURN_TIMEOUT - 1) : '0;

   logic [TIMER_W-1:0] count;

   // Count up while enabled; clear reloads zero and takes priority.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + TIMER_W'(1);
      end
   end

   assign terminal = (TURN_TIMEOUT > 0) && (count == TC_VALUE);

endmodule

// File: rtl/game_state_ctrl.sv
// rtl/game_state_ctrl.sv - Battleship game sequencer: placement, turns, hits, win, timeout
module game_state_ctrl
   import battleship_pkg::*;
#(
   parameter int SHIP_CELLS   = SHIP_CELLS_DEFAULT,
   parameter int TURN_TIMEOUT = 100_000_000,
   parameter int TIMER_W      = 27,
   parameter int HIT_W        = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               p1_place_done,
   input  logic               p2_place_done,
   input  logic               shot_valid,
   input  logic               shot_hit,
   input  logic               new_game,
   output logic [STATE_W-1:0] state,
   output logic [HIT_W-1:0]   p1_hits,
   output logic [HIT_W-1:0]   p2_hits,
   output logic               turn_timeout
);

   localparam logic [HIT_W-1:0] WIN_AT = HIT_W'(SHIP_CELLS);

   game_state_t      state_q, state_d;
   logic [HIT_W-1:0] p1_d, p2_d;
   logic             timeout_d;
   logic             timer_terminal;
   logic             timer_clear;
   logic             timer_enable;

   // Any state change restarts the timer, so each new turn starts from zero.
   assign timer_clear  = (state_d != state_q);
   assign timer_enable = (state_q == P1_TURN) || (state_q == P2_TURN);

   turn_timer #(
      .TIMER_W      (TIMER_W),
      .TURN_TIMEOUT (TURN_TIMEOUT)
   ) u_turn_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (timer_clear),
      .enable   (timer_enable),
      .terminal (timer_terminal)
   );

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Hit counters and the registered timeout pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         p1_hits      <= '0;
         p2_hits      <= '0;
         turn_timeout <= 1'b0;
      end else begin
         p1_hits      <= p1_d;
         p2_hits      <= p2_d;
         turn_timeout <= timeout_d;
      end
   end

   // Next-state, hit scoring and forfeit decision; a shot beats a same-cycle timeout.
   always_comb begin
      state_d   = state_q;
      p1_d      = p1_hits;
      p2_d      = p2_hits;
      timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = P1_PLACE;
               p1_d    = '0;
               p2_d    = '0;
            end
         end
         P1_PLACE: begin
            if (p1_place_done) state_d = P2_PLACE;
         end
         P2_PLACE: begin
            if (p2_place_done) state_d = P1_TURN;
         end
         P1_TURN: begin
            if (shot_valid) begin
               if (shot_hit && (p1_hits != WIN_AT)) p1_d = p1_hits + HIT_W'(1);
               state_d = (shot_hit && (p1_d == WIN_AT)) ? P1_WIN : P2_TURN;
            end else if (timer_terminal) begin
               state_d   = P2_TURN;
               timeout_d = 1'b1;
            end
         end
         P2_TURN: begin
            if (shot_valid) begin
               if (shot_hit && (p2_hits != WIN_AT)) p2_d = p2_hits + HIT_W'(1);
               state_d = (shot_hit && (p2_d == WIN_AT)) ? P2_WIN : P1_TURN;
            end else if (timer_terminal) begin
               state_d   = P1_TURN;
               timeout_d = 1'b1;
            end
         end
         P1_WIN, P2_WIN: begin
            if (new_game) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign state = state_q;

endmodule

// File: doc/game_state_ctrl.md
Name: game_state_ctrl

Overview:
- Top-level Battleship game sequencer. Drives the 3-bit `state` code consumed by the downstream fire-permission stage; codes 3 and 4 grant fire rights to P1 and P2.
- Walks the game through idle, ship placement, alternating turns and win.
- Counts hits per player, detects the win, and forfeits a turn on inactivity timeout.

Parameters:
- SHIP_CELLS, 17, total occupied ship cells per board; a player wins at this many hits.
- TURN_TIMEOUT, 100_000_000, clk cycles a player may idle in a turn before forfeiting it; 0 disables the timeout.
- TIMER_W, 27, width of the turn timer; must hold TURN_TIMEOUT.
- HIT_W, 5, width of the hit counters; must hold SHIP_CELLS.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  1-cycle pulse, debounced "begin game"
- p1_place_done  input  1  1-cycle pulse, P1 finished placing ships
- p2_place_done  input  1  1-cycle pulse, P2 finished placing ships
- shot_valid  input  1  1-cycle pulse, current player fired; result resolved the same cycle
- shot_hit  input  1  qualifies shot_valid: 1 = hit, 0 = miss
- new_game  input  1  1-cycle pulse, return from a win state to idle
- state  output  3  registered game state code
- p1_hits  output  HIT_W  hits scored by P1 on P2's board
- p2_hits  output  HIT_W  hits scored by P2 on P1's board
- turn_timeout  output  1  1-cycle pulse when a turn is forfeited

Behaviour:
- Reset value of every output is 0: state=IDLE(0), both hit counts 0, turn_timeout 0. The turn timer also resets to 0.
- State codes (fixed; downstream decodes 3 and 4):
  - IDLE=0, P1_PLACE=1, P2_PLACE=2, P1_TURN=3, P2_TURN=4, P1_WIN=5, P2_WIN=6.
  - Code 7 is unused; if reached, the next state is IDLE.
- Transitions are evaluated on each posedge clk and the new state is visible the next cycle (1-cycle latency).
  - IDLE: start -> P1_PLACE. On entry to P1_PLACE, p1_hits and p2_hits clear to 0.
  - P1_PLACE: p1_place_done -> P2_PLACE.
  - P2_PLACE: p2_place_done -> P1_TURN.
  - P1_TURN, on shot_valid:
    - If shot_hit, p1_hits increments.
    - If the incremented value == SHIP_CELLS -> P1_WIN, else -> P2_TURN.
    - A miss -> P2_TURN.
  - P2_TURN: mirror of P1_TURN, using p2_hits and P2_WIN.
  - P1_WIN / P2_WIN: hold; new_game -> IDLE. Hit counts hold until the next P1_PLACE entry.
- Input qualification:
  - Inputs not listed for the current state are ignored, e.g. start mid-game, shot_valid in placement, place_done in turns.
  - shot_hit is ignored when shot_valid=0.
- Turn timer:
  - Clears to 0 on every entry to P1_TURN or P2_TURN.
  - Increments each cycle while in a turn state.
  - When timer == TURN_TIMEOUT-1 and no shot_valid that cycle: switch to the other player's turn, hit counts unchanged, turn_timeout pulses high for 1 cycle (registered, aligned with the new state).
  - If shot_valid and the timeout fall in the same cycle, the shot wins and no timeout pulse is issued.
- Hit counters saturate at SHIP_CELLS and never wrap; the win transition makes further increments unreachable.
- Asynchronous reset mid-game returns to IDLE immediately, clears all counters, and deasserts turn_timeout.

Decomposition:
- Shared package `battleship_pkg` holds:
  - The 3-bit state code constants IDLE..P2_WIN, shared with the downstream fire-permission stage and the display logic.
  - The STATE_W=3 constant.
  - The default SHIP_CELLS.
- One natural sub-module, `turn_timer`: a loadable up-counter with clear, enable and terminal-count output, parameterised by TIMER_W and TURN_TIMEOUT.

Test Plan:
- Reset, then start; p1_place_done; p2_place_done -> state sequence 0,1,2,3, each step one cycle after its pulse; hits both 0.
- In P1_TURN: shot_valid with shot_hit=1 -> p1_hits=1, state=4. Then shot_valid with shot_hit=0 -> p2_hits=0, state=3.
- SHIP_CELLS=3: three P1 hits interleaved with P2 misses -> state=5 after the third hit, p1_hits=3. Later shot_valid pulses are ignored; new_game -> 0.
- TURN_TIMEOUT=10: no shot in P1_TURN -> after 10 cycles state=4, turn_timeout high for exactly 1 cycle. Separately, shot_valid on cycle 10 -> normal shot handling, no timeout pulse.
- start during P2_TURN and shot_valid during P1_PLACE -> no state or counter change.
- reset asserted low in P2_TURN with p1_hits=2 -> state=0 and counters 0 immediately (asynchronous), before the next clk edge.
